// File: rtl/rice_core_pkg.sv
// rice_core_pkg: shared types and helpers for the rice core pipeline tracker.

// Declares the trace record type inside a module. The seq field uses the
// enclosing scope's COUNTER_WIDTH so the record always matches the counters.
`define RICE_CORE_DEFINE_TYPES(XLEN_W) \
    typedef struct packed { \
        logic [(XLEN_W)-1:0]      pc; \
        logic [COUNTER_WIDTH-1:0] seq; \
    } rice_core_trace_entry_t

package rice_core_pkg;

    // Saturating increment for counters up to 64 bits wide. Callers zero-extend
    // their counter into value and truncate the result back to their width.
    function automatic logic [63:0] rice_core_sat_inc(
        input logic [63:0]  value,
        input logic         inc,
        input int unsigned  width
    );
        logic [63:0] max_v;
        if (width >= 64) begin
            max_v = {64{1'b1}};
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        if (inc && (value != max_v)) begin
            rice_core_sat_inc = value + 64'd1;
        end else begin
            rice_core_sat_inc = value;
        end
    endfunction

endpackage

// File: rtl/rice_core_trace_fifo.sv
// rice_core_trace_fifo: single-clock FIFO with a registered head entry.
// The head register is the first slot, so a push into an empty FIFO is
// visible on the next cycle; the backing array holds the remaining entries.
module rice_core_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 96
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    mem_cnt_r;
    logic             head_valid_r;
    logic [WIDTH-1:0] head_data_r;

    logic pop_s, full_s, push_ok_s, mem_empty_s, direct_s, mem_wr_s, mem_rd_s;

    // Decide where an accepted push lands and whether the head refills from memory.
    always_comb begin
        pop_s       = pop & head_valid_r;
        full_s      = (mem_cnt_r + CW'(head_valid_r)) == CW'(DEPTH);
        push_ok_s   = push & (~full_s | pop_s);
        mem_empty_s = (mem_cnt_r == CW'(0));
        direct_s    = push_ok_s & (~head_valid_r | (pop_s & mem_empty_s));
        mem_wr_s    = push_ok_s & ~direct_s;
        mem_rd_s    = pop_s & ~mem_empty_s;
    end

    // Head register and pointer/occupancy state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_valid_r <= 1'b0;
            head_data_r  <= {WIDTH{1'b0}};
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            mem_cnt_r    <= {CW{1'b0}};
        end else begin
            if (mem_rd_s) begin
                head_data_r  <= mem_r[rd_ptr_r];
                head_valid_r <= 1'b1;
            end else if (direct_s) begin
                head_data_r  <= push_data;
                head_valid_r <= 1'b1;
            end else if (pop_s) begin
                head_valid_r <= 1'b0;
            end
            if (mem_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (mem_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            mem_cnt_r <= mem_cnt_r + CW'(mem_wr_s) - CW'(mem_rd_s);
        end
    end

    // Backing storage; contents are only read behind a valid occupancy count.
    always_ff @(posedge i_clk) begin
        if (mem_wr_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign full       = full_s;
    assign empty      = ~head_valid_r;
    assign head_valid = head_valid_r;
    assign head_data  = head_data_r;

endmodule

// File: rtl/rice_core_pipeline_tracker.sv
// rice_core_pipeline_tracker: tracks in-flight fetch requests across flushes,
// streams retired PCs through a buffered trace port and keeps perf counters.
module rice_core_pipeline_tracker
    import rice_core_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TRACE_DEPTH     = 8,
    parameter int COUNTER_WIDTH   = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_inst_request_valid,
    input  logic                                 i_inst_request_ack,
    input  logic                                 i_if_valid,
    input  logic                                 i_wb_valid,
    input  logic [XLEN-1:0]                      i_wb_pc,
    input  logic                                 i_flush,
    output logic                                 o_trace_valid,
    input  logic                                 i_trace_ready,
    output logic [XLEN-1:0]                      o_trace_pc,
    output logic [COUNTER_WIDTH-1:0]             o_trace_seq,
    output logic                                 o_trace_overflow,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_stale,
    output logic [COUNTER_WIDTH-1:0]             o_cycle_count,
    output logic [COUNTER_WIDTH-1:0]             o_retire_count,
    output logic [COUNTER_WIDTH-1:0]             o_flush_count,
    output logic [COUNTER_WIDTH-1:0]             o_squash_count,
    output logic                                 o_error
);
    `RICE_CORE_DEFINE_TYPES(XLEN);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

    logic [OW-1:0]            outstanding_r, stale_r, outstanding_nxt_s, stale_nxt_s;
    logic [COUNTER_WIDTH-1:0] cycle_r, retire_r, flush_r, squash_r, seq_r;
    logic                     overflow_r, error_r;
    logic                     issue_s, resp_ok_s, at_max_s, issue_ok_s, squash_ev_s;
    logic                     err_ev_s, pop_s, drop_s;
    logic                     fifo_full_s, fifo_empty_s, fifo_valid_s;
    rice_core_trace_entry_t   push_entry_s, head_entry_s;

    // Fetch bookkeeping: a response with nothing in flight is ignored and
    // flagged, and an issue past capacity is flagged and not counted.
    always_comb begin
        issue_s      = i_inst_request_valid & i_inst_request_ack;
        resp_ok_s    = i_if_valid & (outstanding_r != OW'(0));
        at_max_s     = (outstanding_r == MAX_OUT_C);
        issue_ok_s   = issue_s & (~at_max_s | resp_ok_s);
        err_ev_s     = (issue_s & at_max_s & ~resp_ok_s) |
                       (i_if_valid & (outstanding_r == OW'(0)));
        outstanding_nxt_s = outstanding_r + OW'(issue_ok_s) - OW'(resp_ok_s);
        stale_nxt_s  = stale_r;
        squash_ev_s  = 1'b0;
        if (i_flush) begin
            // Everything still in flight before this cycle's issue is now dead.
            stale_nxt_s = outstanding_r - OW'(resp_ok_s);
            squash_ev_s = resp_ok_s;
        end else if (resp_ok_s && (stale_r != OW'(0))) begin
            stale_nxt_s = stale_r - OW'(1'b1);
            squash_ev_s = 1'b1;
        end else begin
            stale_nxt_s = stale_r;
            squash_ev_s = 1'b0;
        end
        pop_s             = i_trace_ready & ~fifo_empty_s;
        drop_s            = i_wb_valid & fifo_full_s & ~pop_s;
        push_entry_s.pc   = i_wb_pc;
        push_entry_s.seq  = seq_r;
    end

    // Tracker state, sticky flags and saturating counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_r <= {OW{1'b0}};
            stale_r       <= {OW{1'b0}};
            cycle_r       <= {COUNTER_WIDTH{1'b0}};
            retire_r      <= {COUNTER_WIDTH{1'b0}};
            flush_r       <= {COUNTER_WIDTH{1'b0}};
            squash_r      <= {COUNTER_WIDTH{1'b0}};
            seq_r         <= {COUNTER_WIDTH{1'b0}};
            overflow_r    <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            outstanding_r <= outstanding_nxt_s;
            stale_r       <= stale_nxt_s;
            cycle_r       <= COUNTER_WIDTH'(rice_core_sat_inc(64'(cycle_r), 1'b1, COUNTER_WIDTH));
            retire_r      <= COUNTER_WIDTH'(rice_core_sat_inc(64'(retire_r), i_wb_valid, COUNTER_WIDTH));
            flush_r       <= COUNTER_WIDTH'(rice_core_sat_inc(64'(flush_r), i_flush, COUNTER_WIDTH));
            squash_r      <= COUNTER_WIDTH'(rice_core_sat_inc(64'(squash_r), squash_ev_s, COUNTER_WIDTH));
            // Seq advances on every retire, dropped or not, and wraps.
            seq_r         <= seq_r + COUNTER_WIDTH'(i_wb_valid);
            overflow_r    <= overflow_r | drop_s;
            error_r       <= error_r | err_ev_s;
        end
    end

    rice_core_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH ($bits(rice_core_trace_entry_t))
    ) u_trace_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .push       (i_wb_valid),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head_valid (fifo_valid_s),
        .head_data  (head_entry_s)
    );

    assign o_trace_valid    = fifo_valid_s;
    assign o_trace_pc       = head_entry_s.pc;
    assign o_trace_seq      = head_entry_s.seq;
    assign o_trace_overflow = overflow_r;
    assign o_outstanding    = outstanding_r;
    assign o_stale          = stale_r;
    assign o_cycle_count    = cycle_r;
    assign o_retire_count   = retire_r;
    assign o_flush_count    = flush_r;
    assign o_squash_count   = squash_r;
    assign o_error          = error_r;

endmodule

// File: tb/tb_rice_core_pipeline_tracker.sv
// Testbench for rice_core_pipeline_tracker: directed scenarios plus random
// traffic against a queue/integer reference model.
module tb_rice_core_pipeline_tracker;
    localparam int  MAXO  = 4;
    localparam int  DEPTH = 8;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_inst_request_valid = 1'b0, i_inst_request_ack = 1'b0;
    logic        i_if_valid = 1'b0, i_wb_valid = 1'b0, i_flush = 1'b0;
    logic        i_trace_ready = 1'b0;
    logic [63:0] i_wb_pc = 64'd0;

    logic        o_trace_valid, o_trace_overflow, o_error;
    logic [63:0] o_trace_pc;
    logic [31:0] o_trace_seq, o_cycle_count, o_retire_count, o_flush_count, o_squash_count;
    logic [2:0]  o_outstanding, o_stale;

    logic        s_trace_valid, s_trace_overflow, s_error;
    logic [31:0] s_trace_pc;
    logic [3:0]  s_trace_seq, s_cycle_count, s_retire_count, s_flush_count, s_squash_count;
    logic [2:0]  s_outstanding, s_stale;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_out, m_stale;
    longint      m_cycle, m_retire, m_flush, m_squash;
    logic [31:0] m_seq;
    bit          m_ovf, m_err;
    logic [63:0] q_pc[$];
    logic [31:0] q_seq[$];

    rice_core_pipeline_tracker dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_inst_request_valid(i_inst_request_valid), .i_inst_request_ack(i_inst_request_ack),
        .i_if_valid(i_if_valid), .i_wb_valid(i_wb_valid), .i_wb_pc(i_wb_pc), .i_flush(i_flush),
        .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(o_trace_pc), .o_trace_seq(o_trace_seq), .o_trace_overflow(o_trace_overflow),
        .o_outstanding(o_outstanding), .o_stale(o_stale),
        .o_cycle_count(o_cycle_count), .o_retire_count(o_retire_count),
        .o_flush_count(o_flush_count), .o_squash_count(o_squash_count), .o_error(o_error)
    );

    rice_core_pipeline_tracker #(.XLEN(32), .COUNTER_WIDTH(4)) dut_sat (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_inst_request_valid(i_inst_request_valid), .i_inst_request_ack(i_inst_request_ack),
        .i_if_valid(i_if_valid), .i_wb_valid(i_wb_valid), .i_wb_pc(i_wb_pc[31:0]), .i_flush(i_flush),
        .o_trace_valid(s_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(s_trace_pc), .o_trace_seq(s_trace_seq), .o_trace_overflow(s_trace_overflow),
        .o_outstanding(s_outstanding), .o_stale(s_stale),
        .o_cycle_count(s_cycle_count), .o_retire_count(s_retire_count),
        .o_flush_count(s_flush_count), .o_squash_count(s_squash_count), .o_error(s_error)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_out = 0; m_stale = 0;
        m_cycle = 0; m_retire = 0; m_flush = 0; m_squash = 0;
        m_seq = 32'd0; m_ovf = 1'b0; m_err = 1'b0;
        q_pc.delete(); q_seq.delete();
    endtask

    task automatic idle_inputs();
        i_inst_request_valid = 1'b0; i_inst_request_ack = 1'b0;
        i_if_valid = 1'b0; i_wb_valid = 1'b0; i_flush = 1'b0; i_wb_pc = 64'd0;
    endtask

    // Apply the spec's rules to the current inputs, then advance one clock.
    task automatic tick();
        bit issue, resp, popped;
        int nxt;
        issue = i_inst_request_valid && i_inst_request_ack;
        resp  = i_if_valid && (m_out > 0);
        if ((i_if_valid && m_out == 0) || (issue && m_out == MAXO && !resp)) m_err = 1'b1;
        if (i_flush) begin
            m_stale = m_out - int'(resp);
            if (resp) m_squash = sat(m_squash + 1);
        end else if (resp && m_stale > 0) begin
            m_stale--;
            m_squash = sat(m_squash + 1);
        end
        nxt = m_out - int'(resp);
        if (issue && nxt < MAXO) nxt++;
        m_out = nxt;
        popped = i_trace_ready && (q_pc.size() > 0);
        if (popped) begin
            void'(q_pc.pop_front());
            void'(q_seq.pop_front());
        end
        if (i_wb_valid) begin
            if (q_pc.size() < DEPTH) begin
                q_pc.push_back(i_wb_pc);
                q_seq.push_back(m_seq);
            end else begin
                m_ovf = 1'b1;
            end
            m_seq = m_seq + 32'd1;
            m_retire = sat(m_retire + 1);
        end
        if (i_flush) m_flush = sat(m_flush + 1);
        m_cycle = sat(m_cycle + 1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_wb_valid = 1'b1; i_wb_pc = 64'h40 + 64'(i);
            i_inst_request_valid = 1'b1; i_inst_request_ack = 1'b1; i_flush = (i == 2);
            tick();
        end
        idle_inputs();
        #3;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_trace_valid !== 1'b0 || o_trace_pc !== 64'd0 || o_trace_seq !== 32'd0 ||
            o_trace_overflow !== 1'b0 || o_outstanding !== 3'd0 || o_stale !== 3'd0 ||
            o_cycle_count !== 32'd0 || o_retire_count !== 32'd0 || o_flush_count !== 32'd0 ||
            o_squash_count !== 32'd0 || o_error !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: valid=%0b pc=%0h seq=%0d out=%0d cyc=%0d ret=%0d flush=%0d required all zero",
                     o_trace_valid, o_trace_pc, o_trace_seq, o_outstanding, o_cycle_count,
                     o_retire_count, o_flush_count);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if (o_cycle_count !== 32'd1) begin
            n_errors++;
            $display("FAIL reset_cycle_count: got %0d required 1", o_cycle_count);
        end
        n_checks++;
        if (o_trace_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_fifo_cleared: valid=%0b required 0", o_trace_valid);
        end
    endtask

    task automatic test_flush_squash();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            i_inst_request_valid = 1'b1; i_inst_request_ack = 1'b1;
            tick();
        end
        i_flush = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (o_outstanding !== 3'd4 || o_stale !== 3'd3) begin
            n_errors++;
            $display("FAIL flush_stale: outstanding=%0d stale=%0d required 4 and 3", o_outstanding, o_stale);
        end
        for (int i = 0; i < 4; i++) begin
            i_if_valid = 1'b1;
            tick();
        end
        idle_inputs();
        n_checks++;
        if (o_squash_count !== 32'd3 || o_stale !== 3'd0 || o_outstanding !== 3'd0 || o_error !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_drain: squash=%0d stale=%0d outstanding=%0d error=%0b required 3 0 0 0",
                     o_squash_count, o_stale, o_outstanding, o_error);
        end
        n_checks++;
        if (o_flush_count !== 32'd1) begin
            n_errors++;
            $display("FAIL flush_count: got %0d required 1", o_flush_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        i_trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_wb_valid = 1'b1; i_wb_pc = 64'h1000 + 64'(4 * i);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (o_trace_overflow !== 1'b1 || o_retire_count !== 32'd10) begin
            n_errors++;
            $display("FAIL overflow_flag: overflow=%0b retire=%0d required 1 and 10", o_trace_overflow, o_retire_count);
        end
        i_trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (o_trace_valid !== 1'b1 || o_trace_pc !== 64'h1000 + 64'(4 * k) || o_trace_seq !== 32'(k)) begin
                n_errors++;
                $display("FAIL overflow_drain[%0d]: valid=%0b pc=%0h seq=%0d required 1 %0h %0d",
                         k, o_trace_valid, o_trace_pc, o_trace_seq, 64'h1000 + 64'(4 * k), k);
            end
            tick();
        end
        n_checks++;
        if (o_trace_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_empty: valid=%0b required 0", o_trace_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            i_wb_valid = 1'b1; i_wb_pc = {$urandom, $urandom};
            i_trace_ready = (i % 2 == 1);
            tick();
            n_checks++;
            if (o_trace_valid !== (q_pc.size() > 0) || o_trace_overflow !== m_ovf ||
                (q_pc.size() > 0 && (o_trace_pc !== q_pc[0] || o_trace_seq !== q_seq[0]))) begin
                n_errors++;
                $display("FAIL back_to_back[%0d]: valid=%0b pc=%0h seq=%0d ovf=%0b required valid=%0b ovf=%0b",
                         i, o_trace_valid, o_trace_pc, o_trace_seq, o_trace_overflow, q_pc.size() > 0, m_ovf);
            end
        end
        idle_inputs();
    endtask

    task automatic test_errors();
        do_reset();
        i_if_valid = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (o_error !== 1'b1 || o_outstanding !== 3'd0) begin
            n_errors++;
            $display("FAIL err_underflow: error=%0b outstanding=%0d required 1 0", o_error, o_outstanding);
        end
        do_reset();
        i_inst_request_valid = 1'b1; i_inst_request_ack = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (o_error !== 1'b0 || o_outstanding !== 3'd4) begin
            n_errors++;
            $display("FAIL err_full_ok: error=%0b outstanding=%0d required 0 4", o_error, o_outstanding);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (o_error !== 1'b1 || o_outstanding !== 3'd4) begin
            n_errors++;
            $display("FAIL err_overissue: error=%0b outstanding=%0d required 1 4", o_error, o_outstanding);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            i_inst_request_valid = ($urandom_range(0, 99) < 55);
            i_inst_request_ack   = ($urandom_range(0, 99) < 70);
            i_if_valid           = ($urandom_range(0, 99) < 40);
            i_flush              = ($urandom_range(0, 99) < 10);
            i_wb_valid           = ($urandom_range(0, 99) < 50);
            i_wb_pc              = {$urandom, $urandom};
            i_trace_ready        = ($urandom_range(0, 99) < 60);
            tick();
            n_checks++;
            if (o_outstanding !== 3'(m_out) || o_stale !== 3'(m_stale) || o_error !== m_err ||
                o_trace_overflow !== m_ovf || o_trace_valid !== (q_pc.size() > 0) ||
                o_cycle_count !== m_cycle[31:0] || o_retire_count !== m_retire[31:0] ||
                o_flush_count !== m_flush[31:0] || o_squash_count !== m_squash[31:0] ||
                (q_pc.size() > 0 && (o_trace_pc !== q_pc[0] || o_trace_seq !== q_seq[0]))) begin
                n_errors++;
                $display("FAIL random[%0d]: out=%0d/%0d stale=%0d/%0d err=%0b/%0b squash=%0d/%0d ret=%0d/%0d valid=%0b/%0b seq=%0d",
                         i, o_outstanding, m_out, o_stale, m_stale, o_error, m_err,
                         o_squash_count, m_squash, o_retire_count, m_retire,
                         o_trace_valid, q_pc.size() > 0, o_trace_seq);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        i_trace_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (s_cycle_count !== 4'd15) begin
            n_errors++;
            $display("FAIL sat_cycle: got %0d required 15", s_cycle_count);
        end
        for (int i = 0; i < 17; i++) begin
            i_wb_valid = 1'b1; i_wb_pc = 64'(i);
            tick();
            n_checks++;
            if (s_trace_valid !== 1'b1 || s_trace_seq !== 4'(i % 16)) begin
                n_errors++;
                $display("FAIL sat_seq[%0d]: valid=%0b seq=%0d required 1 %0d", i, s_trace_valid, s_trace_seq, i % 16);
            end
        end
        idle_inputs();
        n_checks++;
        if (s_retire_count !== 4'd15 || o_retire_count !== 32'd17) begin
            n_errors++;
            $display("FAIL sat_retire: narrow=%0d wide=%0d required 15 and 17", s_retire_count, o_retire_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_flush_squash();
        test_overflow();
        test_back_to_back();
        test_errors();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
